// File: rtl/mem_access_unit_if.sv
// Data-memory request/acknowledge bus between the load/store unit and data memory.
interface mem_access_unit_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: one outstanding data-memory transaction, lane steering,
// load alignment/extension, pipeline stall, misalignment and bus-timeout reporting.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  mem_load_type,
    input  logic [1:0]  mem_store_type,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic        wb_valid,
    output logic [31:0] load_data,
    output logic        misalign,
    output logic        bus_err,
    mem_access_unit_if.master dmem
);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_e;

    localparam logic [2:0] LT_LB  = 3'b000;
    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LW  = 3'b010;
    localparam logic [2:0] LT_LBU = 3'b011;
    localparam logic [2:0] LT_LHU = 3'b100;
    localparam logic [1:0] ST_SB  = 2'b00;
    localparam logic [1:0] ST_SH  = 2'b01;
    localparam logic [1:0] ST_SW  = 2'b10;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_NONE = 2'd3;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 32'd1);

    // Access width of the request; SZ_NONE covers DEF and unused type codes.
    function automatic logic [1:0] access_size(input logic rd, input logic [2:0] lt,
                                               input logic [1:0] st);
        logic [1:0] sz;
        if (rd) begin
            case (lt)
                LT_LB, LT_LBU: sz = SZ_BYTE;
                LT_LH, LT_LHU: sz = SZ_HALF;
                LT_LW:         sz = SZ_WORD;
                default:       sz = SZ_NONE;
            endcase
        end else begin
            case (st)
                ST_SB:   sz = SZ_BYTE;
                ST_SH:   sz = SZ_HALF;
                ST_SW:   sz = SZ_WORD;
                default: sz = SZ_NONE;
            endcase
        end
        return sz;
    endfunction

    function automatic logic is_aligned(input logic [1:0] sz, input logic [1:0] off);
        logic ok;
        case (sz)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~off[0];
            SZ_WORD: ok = (off == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] byte_enable(input logic [1:0] sz, input logic [1:0] off);
        logic [3:0] be;
        case (sz)
            SZ_BYTE: be = 4'b0001 << off;
            SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_data(input logic [1:0] sz, input logic [31:0] sd);
        logic [31:0] wd;
        case (sz)
            SZ_BYTE: wd = {4{sd[7:0]}};
            SZ_HALF: wd = {2{sd[15:0]}};
            default: wd = sd;
        endcase
        return wd;
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] lt, input logic [1:0] off,
                                                 input logic [31:0] rdata);
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [31:0] res;
        byte_v = rdata[{off, 3'b000} +: 8];
        half_v = off[1] ? rdata[31:16] : rdata[15:0];
        case (lt)
            LT_LB:   res = {{24{byte_v[7]}}, byte_v};
            LT_LBU:  res = {24'd0, byte_v};
            LT_LH:   res = {{16{half_v[15]}}, half_v};
            LT_LHU:  res = {16'd0, half_v};
            default: res = rdata;
        endcase
        return res;
    endfunction

    state_e      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [2:0]  ltype_q, ltype_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] load_data_q, load_data_d;
    logic        wb_valid_q, wb_valid_d;
    logic        misalign_q, misalign_d;
    logic        bus_err_q, bus_err_d;

    logic [1:0]  size_s;
    logic        request_s;
    logic        aligned_s;
    logic        accept_s;
    logic        timeout_hit_s;

    assign size_s        = access_size(mem_read, mem_load_type, mem_store_type);
    assign request_s     = in_valid && (mem_read || mem_write) && (size_s != SZ_NONE);
    assign aligned_s     = is_aligned(size_s, addr[1:0]);
    assign accept_s      = (state_q == S_IDLE) && request_s && aligned_s;
    assign timeout_hit_s = (wait_cnt_q == TIMEOUT_LAST);

    // Stall is gated by rst_n so a held reset never freezes the pipeline.
    assign stall = rst_n && (accept_s ||
                   ((state_q == S_ACCESS) && !dmem.dmem_ack && !timeout_hit_s));

    // Next-state and next-output computation for the transaction FSM.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        ltype_d     = ltype_q;
        off_d       = off_q;
        load_data_d = load_data_q;
        wb_valid_d  = 1'b0;
        misalign_d  = 1'b0;
        bus_err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d    = S_ACCESS;
                    wait_cnt_d = 8'd0;
                    req_d      = 1'b1;
                    we_d       = !mem_read;
                    addr_d     = {addr[31:2], 2'b00};
                    be_d       = byte_enable(size_s, addr[1:0]);
                    wdata_d    = mem_read ? 32'd0 : lane_data(size_s, store_data);
                    ltype_d    = mem_load_type;
                    off_d      = addr[1:0];
                end else if (request_s) begin
                    misalign_d = 1'b1;
                end else begin
                    misalign_d = 1'b0;
                end
            end
            S_ACCESS: begin
                if (dmem.dmem_ack) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                    if (!we_q) begin
                        load_data_d = load_extract(ltype_q, off_q, dmem.dmem_rdata);
                        wb_valid_d  = 1'b1;
                    end else begin
                        wb_valid_d  = 1'b0;
                    end
                end else if (timeout_hit_s) begin
                    state_d   = S_IDLE;
                    req_d     = 1'b0;
                    bus_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State and registered-output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wait_cnt_q  <= 8'd0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            be_q        <= 4'd0;
            ltype_q     <= 3'd0;
            off_q       <= 2'd0;
            load_data_q <= 32'd0;
            wb_valid_q  <= 1'b0;
            misalign_q  <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            ltype_q     <= ltype_d;
            off_q       <= off_d;
            load_data_q <= load_data_d;
            wb_valid_q  <= wb_valid_d;
            misalign_q  <= misalign_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign dmem.dmem_be    = be_q;
    assign load_data       = load_data_q;
    assign wb_valid        = wb_valid_q;
    assign misalign        = misalign_q;
    assign bus_err         = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed plus randomized bench for mem_access_unit against an arithmetic reference model.
module tb_mem_access_unit;
    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  mem_load_type = 3'd0;
    logic [1:0]  mem_store_type = 2'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] store_data = 32'd0;
    logic        stall, wb_valid, misalign, bus_err;
    logic [31:0] load_data;

    mem_access_unit_if dmem();

    mem_access_unit #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mem_read(mem_read),
        .mem_write(mem_write), .mem_load_type(mem_load_type),
        .mem_store_type(mem_store_type), .addr(addr), .store_data(store_data),
        .stall(stall), .wb_valid(wb_valid), .load_data(load_data),
        .misalign(misalign), .bus_err(bus_err), .dmem(dmem)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic        pend_wb = 1'b0;
    logic        pend_mis = 1'b0;
    logic        pend_be = 1'b0;
    logic [31:0] model_load = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pulses and load result expected in this cycle from the previous one.
    task automatic chk_flags();
        chk("wb_valid", {31'd0, wb_valid}, {31'd0, pend_wb});
        chk("misalign", {31'd0, misalign}, {31'd0, pend_mis});
        chk("bus_err", {31'd0, bus_err}, {31'd0, pend_be});
        chk("load_data", load_data, model_load);
        pend_wb  = 1'b0;
        pend_mis = 1'b0;
        pend_be  = 1'b0;
    endtask

    // Access size in bytes, 0 when no access happens.
    function automatic int msize(input bit rd, input logic [2:0] lt, input logic [1:0] st);
        if (rd) begin
            if (lt == 3'd0 || lt == 3'd3) return 1;
            if (lt == 3'd1 || lt == 3'd4) return 2;
            if (lt == 3'd2) return 4;
            return 0;
        end
        if (st == 2'd0) return 1;
        if (st == 2'd1) return 2;
        if (st == 2'd2) return 4;
        return 0;
    endfunction

    task automatic idle_cycle(input bit neither);
        @(negedge clk);
        in_valid = neither;
        mem_read = 1'b0;
        mem_write = 1'b0;
        addr = $urandom & 32'hFFFF_FFFC;
        dmem.dmem_ack = 1'($urandom % 2);
        dmem.dmem_rdata = $urandom;
        #1;
        chk_flags();
        chk("idle_stall", {31'd0, stall}, 32'd0);
        chk("idle_req", {31'd0, dmem.dmem_req}, 32'd0);
    endtask

    // One instruction; delay = ACCESS cycles before ack, negative = never ack.
    task automatic run_txn(input bit rd, input logic [2:0] lt, input logic [1:0] st,
                           input logic [31:0] a, input logic [31:0] sd,
                           input logic [31:0] rdata, input int delay);
        int          sz;
        bit          ok;
        bit          ack_now;
        logic [31:0] exp_be, exp_wd, v, mask;
        sz = msize(rd, lt, st);
        ok = (sz != 0) && ((a % 32'(sz)) == 32'd0);
        @(negedge clk);
        in_valid = 1'b1;
        mem_read = rd;
        mem_write = rd ? 1'($urandom % 2) : 1'b1;
        mem_load_type = lt;
        mem_store_type = st;
        addr = a;
        store_data = sd;
        dmem.dmem_ack = 1'($urandom % 2);
        dmem.dmem_rdata = $urandom;
        #1;
        chk_flags();
        chk("accept_stall", {31'd0, stall}, {31'd0, ok});
        chk("req_before", {31'd0, dmem.dmem_req}, 32'd0);
        if (sz != 0 && !ok) pend_mis = 1'b1;
        if (ok) begin
            exp_be = 32'(((1 << sz) - 1) << (a % 4));
            if (sz == 1) exp_wd = (sd & 32'hFF) * 32'h0101_0101;
            else if (sz == 2) exp_wd = (sd & 32'hFFFF) * 32'h0001_0001;
            else exp_wd = sd;
            for (int k = 1; k <= T; k++) begin
                ack_now = (delay >= 0) && (k == delay + 1);
                @(negedge clk);
                dmem.dmem_ack = ack_now;
                dmem.dmem_rdata = ack_now ? rdata : $urandom;
                #1;
                chk("req", {31'd0, dmem.dmem_req}, 32'd1);
                chk("addr", dmem.dmem_addr, a & 32'hFFFF_FFFC);
                chk("we", {31'd0, dmem.dmem_we}, {31'd0, !rd});
                chk("be", {28'd0, dmem.dmem_be}, exp_be);
                if (!rd) chk("wdata", dmem.dmem_wdata, exp_wd);
                chk("access_stall", {31'd0, stall}, {31'd0, (!ack_now && k < T)});
                if (ack_now) break;
            end
            if (delay < 0) begin
                pend_be = 1'b1;
            end else if (rd) begin
                mask = (sz == 4) ? 32'hFFFF_FFFF : 32'((64'd1 << (8 * sz)) - 64'd1);
                v = (rdata >> (8 * (a % 4))) & mask;
                if ((lt == 3'd0 || lt == 3'd1) && v[8 * sz - 1]) v = v | ~mask;
                model_load = v;
                pend_wb = 1'b1;
            end
        end
    endtask

    logic [2:0] lt_pool [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};

    initial begin
        dmem.dmem_ack = 1'b0;
        dmem.dmem_rdata = 32'd0;
        in_valid = 1'b1;
        mem_read = 1'b1;
        mem_load_type = 3'd2;
        #1;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_req", {31'd0, dmem.dmem_req}, 32'd0);
        chk("rst_addr", dmem.dmem_addr, 32'd0);
        chk("rst_be", {28'd0, dmem.dmem_be}, 32'd0);
        chk_flags();
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        idle_cycle(1'b0);

        run_txn(1'b1, 3'd2, 2'd0, 32'h100, 32'd0, 32'hDEAD_BEEF, 2);
        run_txn(1'b1, 3'd0, 2'd0, 32'h203, 32'd0, 32'h80FF_7F01, 0);
        run_txn(1'b1, 3'd3, 2'd0, 32'h203, 32'd0, 32'h80FF_7F01, 1);
        run_txn(1'b1, 3'd1, 2'd0, 32'h202, 32'd0, 32'h80FF_7F01, 0);
        run_txn(1'b1, 3'd4, 2'd0, 32'h200, 32'd0, 32'h80FF_7F01, 0);
        run_txn(1'b1, 3'd0, 2'd0, 32'h201, 32'd0, 32'h80FF_7F01, 0);
        run_txn(1'b0, 3'd0, 2'd0, 32'h301, 32'h1234_5678, 32'd0, 1);
        run_txn(1'b0, 3'd0, 2'd1, 32'h302, 32'h1234_5678, 32'd0, 0);
        run_txn(1'b1, 3'd2, 2'd0, 32'h102, 32'd0, 32'd0, 0);
        run_txn(1'b0, 3'd0, 2'd1, 32'h105, 32'h1, 32'd0, 0);
        run_txn(1'b1, 3'd7, 2'd3, 32'h100, 32'd0, 32'd0, 0);
        idle_cycle(1'b1);
        run_txn(1'b1, 3'd2, 2'd0, 32'h500, 32'd0, 32'h1111_2222, -1);
        run_txn(1'b0, 3'd0, 2'd2, 32'h600, 32'hCAFE_F00D, 32'd0, 0);
        run_txn(1'b1, 3'd2, 2'd0, 32'h604, 32'd0, 32'hA5A5_5A5A, 0);
        idle_cycle(1'b0);

        // Reset while a load is outstanding.
        @(negedge clk);
        in_valid = 1'b1;
        mem_read = 1'b1;
        mem_load_type = 3'd2;
        addr = 32'h400;
        dmem.dmem_ack = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("pre_rst_req", {31'd0, dmem.dmem_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        model_load = 32'd0;
        chk("async_rst_req", {31'd0, dmem.dmem_req}, 32'd0);
        chk("async_rst_stall", {31'd0, stall}, 32'd0);
        chk("async_rst_addr", dmem.dmem_addr, 32'd0);
        chk("async_rst_wdata", dmem.dmem_wdata, 32'd0);
        chk("async_rst_we", {31'd0, dmem.dmem_we}, 32'd0);
        chk_flags();
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycle(1'b0);

        for (int i = 0; i < 80; i++) begin
            if ($urandom % 8 == 0) idle_cycle(1'($urandom % 2));
            run_txn(1'($urandom % 2), lt_pool[$urandom % 6], 2'($urandom % 4),
                    $urandom, $urandom, $urandom, int'($urandom % 5) - 1);
        end
        idle_cycle(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
